// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the T-rex game sequencer.
package game_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPlaying,
      StGameOver,
      StWaitRelease,
      StRestart
   } game_state_t;

   localparam int unsigned ScoreMax = 99999;
   localparam int unsigned TimerMod = 60;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with synchronous clear; wrap pulses combinationally on the
// enabled cycle that returns the count to zero.
module mod_counter #(
   parameter int unsigned MOD = 60,
   localparam int unsigned W = (MOD > 1) ? $clog2(MOD) : 1
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap
);

   localparam logic [W-1:0] Last = W'(MOD - 1);

   logic [W-1:0] count_q;

   assign wrap  = en && (count_q == Last);
   assign count = count_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         count_q <= '0;
      end else if (en) begin
         count_q <= wrap ? '0 : count_q + 1'b1;
      end
   end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: frame pacing, idle/play/game-over/restart FSM, score and speed.
// Define GAME_CTRL_HISCORE_EN to add the hi_score register and port.
module game_ctrl
   import game_ctrl_pkg::*;
#(
   parameter int unsigned SCORE_DIV        = 6,
   parameter int unsigned SPEED_UP_FRAMES  = 600,
   parameter int unsigned INIT_SPEED       = 6,
   parameter int unsigned MAX_SPEED        = 13,
   parameter int unsigned GAME_OVER_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        jump,
   input  logic        crash,
   output logic        update,
   output logic [5:0]  timer,
   output logic [4:0]  speed,
   output logic [16:0] score,
   output logic        sub_rst,
`ifdef GAME_CTRL_HISCORE_EN
   output logic [16:0] hi_score,
`endif
   output logic [2:0]  state
);

   localparam logic [16:0] ScoreSat  = 17'(ScoreMax);
   localparam logic [4:0]  SpeedInit = 5'(INIT_SPEED);
   localparam logic [4:0]  SpeedMax  = 5'(MAX_SPEED);

   game_state_t state_q, state_d;
   logic        update_q, update_d;
   logic        sub_rst_q, sub_rst_d;
   logic        released_q, released_d;
   logic [4:0]  speed_q, speed_d;
   logic [16:0] score_q, score_d;

   logic tick, play_tick, restart_entry, counter_clr;
   logic score_wrap, speed_wrap, go_done, timer_wrap_unused;
   logic [$clog2(SCORE_DIV)-1:0]        score_div_unused;
   logic [$clog2(SPEED_UP_FRAMES)-1:0]  speed_div_unused;
   logic [$clog2(GAME_OVER_FRAMES)-1:0] go_cnt_unused;

   // RESTART swallows frame ticks entirely.
   assign tick          = frame_tick && (state_q != StRestart);
   // A crash tick still updates, but the score/speed do not advance on it.
   assign play_tick     = tick && (state_q == StPlaying) && !crash;
   assign restart_entry = (state_d == StRestart) && (state_q != StRestart);
   assign counter_clr   = rst || restart_entry;

   mod_counter #(.MOD(TimerMod)) u_timer (
      .clk(clk), .clr(counter_clr), .en(tick), .count(timer), .wrap(timer_wrap_unused)
   );
   mod_counter #(.MOD(SCORE_DIV)) u_score_div (
      .clk(clk), .clr(counter_clr), .en(play_tick), .count(score_div_unused), .wrap(score_wrap)
   );
   mod_counter #(.MOD(SPEED_UP_FRAMES)) u_speed_div (
      .clk(clk), .clr(counter_clr), .en(play_tick), .count(speed_div_unused), .wrap(speed_wrap)
   );
   mod_counter #(.MOD(GAME_OVER_FRAMES)) u_go_cnt (
      .clk(clk), .clr(counter_clr), .en(update_q && (state_q == StGameOver)),
      .count(go_cnt_unused), .wrap(go_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         update_q   <= 1'b0;
         sub_rst_q  <= 1'b1;
         released_q <= 1'b0;
         speed_q    <= SpeedInit;
         score_q    <= '0;
      end else begin
         state_q    <= state_d;
         update_q   <= update_d;
         sub_rst_q  <= sub_rst_d;
         released_q <= released_d;
         speed_q    <= speed_d;
         score_q    <= score_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      released_d = 1'b0;
      unique case (state_q)
         StIdle:        if (update_q && jump) state_d = StPlaying;
         StPlaying:     if (crash) state_d = StGameOver;
         StGameOver:    if (go_done) state_d = StWaitRelease;
         StWaitRelease: begin
            // Only a fresh press after a release may restart the game.
            released_d = released_q || !jump;
            if (released_q && jump) state_d = StRestart;
         end
         StRestart:     state_d = StIdle;
         default:       state_d = StIdle;
      endcase
   end

   always_comb begin
      update_d  = tick;
      sub_rst_d = (state_d == StRestart);
      speed_d   = speed_q;
      score_d   = score_q;
      if (restart_entry) begin
         speed_d = SpeedInit;
         score_d = '0;
      end else begin
         if (score_wrap && (score_q < ScoreSat)) score_d = score_q + 17'd1;
         if (speed_wrap && (speed_q < SpeedMax)) speed_d = speed_q + 5'd1;
      end
   end

`ifdef GAME_CTRL_HISCORE_EN
   logic [16:0] hi_score_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_score_q <= '0;
      end else if ((state_q == StPlaying) && crash && (score_q > hi_score_q)) begin
         hi_score_q <= score_q;
      end
   end

   assign hi_score = hi_score_q;
`endif

   assign update  = update_q;
   assign sub_rst = sub_rst_q;
   assign speed   = speed_q;
   assign score   = score_q;
   assign state   = state_q;

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the T-rex runner. It converts the display's per-frame tick into the `update`, `timer` and `speed` signals consumed by the character and obstacle datapaths. It runs the idle → playing → game-over → restart state machine, keeps score, and issues a one-cycle restart reset to the character and obstacle blocks.

## Interface
- `SCORE_DIV`, 6: frames per score point.
- `SPEED_UP_FRAMES`, 600: frames per speed increment.
- `INIT_SPEED`, 6: speed after reset or restart.
- `MAX_SPEED`, 13: speed saturation value.
- `GAME_OVER_FRAMES`, 30: minimum frames in GAME_OVER before a restart is accepted.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `jump`  in  1  debounced jump button level.
- `crash`  in  1  collision detector output, level.
- `update`  out  1  one-cycle pulse to the datapaths.
- `timer`  out  6  frame counter, 0..59.
- `speed`  out  5  current game speed.
- `score`  out  17  distance score, 0..99999.
- `sub_rst`  out  1  reset to the trex and obstacle blocks.
- `state`  out  3  `game_state_t`, for the HUD.
- `hi_score`  out  17  best score; present only with the macro.

## Operation
- States:
  - IDLE: waiting for the first jump.
  - PLAYING.
  - GAME_OVER: frozen score.
  - WAIT_RELEASE: jump must drop before a restart.
  - RESTART: one cycle.
- IDLE → PLAYING: on an `update` cycle with `jump`=1. This matches the cycle in which the character leaves its waiting state.
- PLAYING → GAME_OVER: on any cycle with `crash`=1. `crash` is ignored in every other state.
- GAME_OVER → WAIT_RELEASE: once `GAME_OVER_FRAMES` updates have been counted in GAME_OVER.
- WAIT_RELEASE:
  - While `jump`=1, stay.
  - After `jump`=0 has been seen, the next `jump`=1 → RESTART.
- RESTART → IDLE, unconditionally.
- `sub_rst`=1 only in RESTART.
- On entering RESTART:
  - score ← 0
  - speed ← `INIT_SPEED`
  - timer ← 0
  - score divider, speed divider and game-over counter ← 0
- `update` pulses on every `frame_tick` in every state except RESTART.
- `timer` increments on each `update` and wraps 59 → 0.
- Score (PLAYING only): the divider counts updates 0..`SCORE_DIV`-1. On wrap, `score` increments and saturates at 99999.
- Speed (PLAYING only): the divider counts updates 0..`SPEED_UP_FRAMES`-1. On wrap, `speed` increments and saturates at `MAX_SPEED`.
- In GAME_OVER and WAIT_RELEASE, `score` and `speed` hold.
- All counters are unsigned, sized with `$clog2` of their modulus. `score` arithmetic is 17-bit.

## Timing
- Reset values: `update`=0, `timer`=0, `speed`=`INIT_SPEED`, `score`=0, `sub_rst`=1 (for the reset cycle only, then 0), `state`=IDLE, `hi_score`=0.
- `update` is registered: high exactly one cycle after `frame_tick`.
- `timer`, `score` and `speed` change in the same edge that raises `update`. Datapaths sampling on `update` therefore see the pre-update values.
- `crash` and `frame_tick` in the same PLAYING cycle: the state goes to GAME_OVER, and the pending `update` still issues next cycle. The score does not advance on that update.
- `frame_tick` during RESTART is dropped (no `update`).
- `rst` mid-game returns to the reset values in one cycle, regardless of state.
- `sub_rst` is a registered output, high for exactly one cycle.

## Configuration
- `GAME_CTRL_HISCORE_EN` defined:
  - A `hi_score` register and port exist.
  - On entry to GAME_OVER, if `score` > `hi_score`, then `hi_score` ← `score`.
  - `hi_score` survives RESTART and is cleared only by `rst`.
- Undefined: no `hi_score` port and no register.

## Structure
- `game_ctrl_pkg` holds:
  - `game_state_t`
  - the score saturation constant 99999
  - the timer modulus 60
- One sub-module, `mod_counter`: parameter MOD, inputs `clr` and `en`, outputs count and `wrap` pulse. It is instantiated for the timer, score divider, speed divider and game-over counter.

## Test plan
- Reset, then 3 `frame_tick`s with `jump`=0:
  - `state`=IDLE, `timer`=3, `score`=0, `speed`=6.
  - Each `update` lags its tick by 1 cycle.
- `jump`=1 at the first update, then 61 ticks:
  - PLAYING, `timer` wraps to 1, `score`=10.
- Play 600 ticks: `speed`=7. Play 4800 ticks: `speed` stays 13.
- Assert `crash` together with a `frame_tick` at score 42:
  - GAME_OVER, `update` still pulses, `score` stays 42.
  - Hold `jump`=1 for 40 ticks: still no RESTART.
  - Release, then press: `sub_rst`=1 for exactly 1 cycle.
  - Then IDLE, `score`=0, `speed`=6, `timer`=0.
- With `GAME_CTRL_HISCORE_EN`:
  - Crash at score 42, `hi_score`=42.
  - Restart, crash at score 17, `hi_score` stays 42.
  - `rst` clears it to 0.
- Assert `rst` in WAIT_RELEASE during a `frame_tick`: next cycle has all reset values and no `update`.
